// File: rtl/sum4_pkg.sv
// Shared constants and types for the four-operand summing scheduler.
package sum4_pkg;

    localparam int NREQ   = 4;      // number of requesters
    localparam int W      = 6;      // operand width
    localparam int LAT    = 3;      // adder-pipe latency in cycles
    localparam int FDEPTH = 8;      // result FIFO depth, also the credit limit
    localparam int SUMW   = W + 2;  // four W-bit operands never overflow W+2 bits
    localparam int IDW    = 2;      // requester index width carried with each result

    // Tag travelling alongside an operation through the adder pipe.
    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/csa4_pipe.sv
// Three-stage carry-save adder for four operands: two CSA layers, then a
// final carry-propagate add. Fixed latency of three cycles, no handshake.
module csa4_pipe
    import sum4_pkg::*;
#(
    parameter int OPW  = W,
    parameter int OUTW = OPW + 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OPW-1:0]  a_i,
    input  logic [OPW-1:0]  b_i,
    input  logic [OPW-1:0]  c_i,
    input  logic [OPW-1:0]  d_i,
    output logic [OUTW-1:0] sum_o
);

    logic [OUTW-1:0] a_x, b_x, c_x, d_x;
    logic [OUTW-1:0] s1_q, c1_q, d1_q;
    logic [OUTW-1:0] s2_q, c2_q;
    logic [OUTW-1:0] sum_q;

    // Zero-extend operands to the result width so all carries are kept.
    always_comb begin
        a_x = OUTW'(a_i);
        b_x = OUTW'(b_i);
        c_x = OUTW'(c_i);
        d_x = OUTW'(d_i);
    end

    // Stage 1: compress a, b, c into sum/carry vectors; delay d alongside.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            c1_q <= '0;
            d1_q <= '0;
        end else begin
            s1_q <= a_x ^ b_x ^ c_x;
            c1_q <= ((a_x & b_x) | (a_x & c_x) | (b_x & c_x)) << 1;
            d1_q <= d_x;
        end
    end

    // Stage 2: fold d into the carry-save pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_q <= '0;
            c2_q <= '0;
        end else begin
            s2_q <= s1_q ^ c1_q ^ d1_q;
            c2_q <= ((s1_q & c1_q) | (s1_q & d1_q) | (c1_q & d1_q)) << 1;
        end
    end

    // Stage 3: resolve the remaining carries with one ripple add.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= s2_q + c2_q;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/sum4_sched.sv
// Round-robin scheduler sharing one four-operand adder pipe among several
// requesters. Results return through a first-word-fall-through FIFO; issue
// is credit-limited so everything in flight always has a FIFO slot.
module sum4_sched
    import sum4_pkg::*;
#(
    parameter int NREQ   = sum4_pkg::NREQ,
    parameter int W      = sum4_pkg::W,
    parameter int LAT    = sum4_pkg::LAT,
    parameter int FDEPTH = sum4_pkg::FDEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*W-1:0] req_c,
    input  logic [NREQ*W-1:0] req_d,
    output logic [NREQ-1:0]   req_ready,
    output logic              res_valid,
    output logic [IDW-1:0]    res_id,
    output logic [W+1:0]      res_sum,
    input  logic              res_ready,
    output logic              busy
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW   = W + 2;
    localparam int FAW  = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
    localparam int CW   = $clog2(FDEPTH + 1);

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [SW-1:0]  sum;
    } entry_t;

    logic [PTRW-1:0] ptr_q, ptr_d;
    logic [PTRW-1:0] winner;
    logic            found;
    logic            issue;
    int              arb_idx;
    logic [W-1:0]    a_sel, b_sel, c_sel, d_sel;
    logic [SW-1:0]   pipe_sum;
    tag_t            tag_q [LAT];
    logic [CW-1:0]   inflight;
    entry_t          mem_q [FDEPTH];
    logic [FAW-1:0]  wr_q, rd_q;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop;
    entry_t          head;

    // Count operations currently travelling through the tag shift register.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + CW'(tag_q[i].valid);
        end
    end

    // Round-robin search from ptr, gated by the FIFO credit and by reset.
    always_comb begin
        winner  = '0;
        found   = 1'b0;
        arb_idx = 0;
        for (int i = 0; i < NREQ; i++) begin
            arb_idx = (int'(ptr_q) + i) % NREQ;
            if (!found && req_valid[arb_idx]) begin
                found  = 1'b1;
                winner = PTRW'(arb_idx);
            end
        end
        issue     = found && !rst && ((int'(inflight) + int'(count_q)) < FDEPTH);
        req_ready = issue ? (NREQ'(1) << winner) : '0;
        ptr_d     = ptr_q;
        if (issue) begin
            ptr_d = (int'(winner) == NREQ - 1) ? '0 : winner + PTRW'(1);
        end
    end

    // Select the current winner's operands for the adder pipe.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        c_sel = '0;
        d_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (int'(winner) == i) begin
                a_sel = req_a[W*i +: W];
                b_sel = req_b[W*i +: W];
                c_sel = req_c[W*i +: W];
                d_sel = req_d[W*i +: W];
            end
        end
    end

    // Round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    csa4_pipe #(
        .OPW  (W),
        .OUTW (SW)
    ) u_pipe (
        .clk   (clk),
        .rst   (rst),
        .a_i   (a_sel),
        .b_i   (b_sel),
        .c_i   (c_sel),
        .d_i   (d_sel),
        .sum_o (pipe_sum)
    );

    // Tag shift register kept in lockstep with the adder pipe stages.
    generate
        for (genvar gi = 0; gi < LAT; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                // First tag stage captures the issue decision.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        tag_q[gi] <= '0;
                    end else begin
                        tag_q[gi].valid <= issue;
                        tag_q[gi].id    <= IDW'(winner);
                    end
                end
            end else begin : g_body
                // Later tag stages just shift.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        tag_q[gi] <= '0;
                    end else begin
                        tag_q[gi] <= tag_q[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign push = tag_q[LAT-1].valid;
    assign pop  = res_valid && res_ready;

    // FIFO storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= {tag_q[LAT-1].id, pipe_sum};
        end
    end

    // Occupancy follows push/pop; a simultaneous pair leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_q <= (int'(wr_q) == FDEPTH - 1) ? '0 : wr_q + FAW'(1);
            end
            if (pop) begin
                rd_q <= (int'(rd_q) == FDEPTH - 1) ? '0 : rd_q + FAW'(1);
            end
            count_q <= count_d;
        end
    end

    assign head      = mem_q[rd_q];
    assign res_valid = (count_q != '0);
    assign res_id    = res_valid ? head.id  : '0;
    assign res_sum   = res_valid ? head.sum : '0;
    assign busy      = (inflight != '0) || (count_q != '0);

    // The credit check must make a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (int'(count_q) == FDEPTH)));

endmodule
